// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO register file and launch/wait sequencer for external multiply and divide units.
// Optional macro DIV_ZERO_EXC_EN: trap divide-by-zero in IDLE instead of launching the divider.
module muldiv_hilo_ctrl #(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult_i,
  input  logic        start_div_i,
  input  logic [31:0] divisor_in_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mult_hi_i,
  input  logic [31:0] mult_lo_i,
  input  logic [31:0] div_hi_i,
  input  logic [31:0] div_lo_i,
  input  logic        mult_done_i,
  input  logic        div_done_i,
  output logic        mult_go_o,
  output logic        div_go_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stall_o,
  output logic        op_done_o,
  output logic        timeout_o,
  output logic        div_zero_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, MULT_WAIT = 2'd1, DIV_WAIT = 2'd2} state_t;

  localparam logic [5:0] TIMEOUT_LIMIT = 6'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [5:0]  wait_cnt_q;
  logic [5:0]  wait_cnt_d;
  logic        limit_hit;
  logic [31:0] hi_q, lo_q;
  logic        mult_go_q, div_go_q, stall_q, op_done_q, timeout_q;
  logic        div_zero_req;

  // Wait counter increment and timeout limit detection
  always_comb begin
    wait_cnt_d = wait_cnt_q + 6'd1;
    limit_hit  = (wait_cnt_q == TIMEOUT_LIMIT);
  end

`ifdef DIV_ZERO_EXC_EN
  logic div_zero_q;
  assign div_zero_req = (divisor_in_i == 32'd0);
  assign div_zero_o   = div_zero_q;
`else
  logic unused_divisor;
  assign unused_divisor = ^divisor_in_i;
  assign div_zero_req   = 1'b0;
  assign div_zero_o     = 1'b0;
`endif

  // Sequencer: state, counter, HI/LO and all registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= 6'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      mult_go_q  <= 1'b0;
      div_go_q   <= 1'b0;
      stall_q    <= 1'b0;
      op_done_q  <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      op_done_q <= 1'b0;
      timeout_q <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
      div_zero_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          wait_cnt_q <= 6'd0;
          if (mthi_i) hi_q <= wdata_i;
          if (mtlo_i) lo_q <= wdata_i;
          // Divide has priority; a trapped divide also swallows a concurrent multiply
          if (start_div_i) begin
            if (div_zero_req) begin
`ifdef DIV_ZERO_EXC_EN
              div_zero_q <= 1'b1;
`endif
            end else begin
              state_q  <= DIV_WAIT;
              div_go_q <= 1'b1;
              stall_q  <= 1'b1;
            end
          end else if (start_mult_i) begin
            state_q   <= MULT_WAIT;
            mult_go_q <= 1'b1;
            stall_q   <= 1'b1;
          end
        end
        MULT_WAIT: begin
          if (mult_done_i || limit_hit) begin
            if (mult_done_i) begin
              hi_q      <= mult_hi_i;
              lo_q      <= mult_lo_i;
              op_done_q <= 1'b1;
            end else begin
              timeout_q <= 1'b1;
            end
            state_q   <= IDLE;
            mult_go_q <= 1'b0;
            stall_q   <= 1'b0;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        DIV_WAIT: begin
          if (div_done_i || limit_hit) begin
            if (div_done_i) begin
              hi_q      <= div_hi_i;
              lo_q      <= div_lo_i;
              op_done_q <= 1'b1;
            end else begin
              timeout_q <= 1'b1;
            end
            state_q  <= IDLE;
            div_go_q <= 1'b0;
            stall_q  <= 1'b0;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        default: begin
          state_q    <= IDLE;
          wait_cnt_q <= 6'd0;
          mult_go_q  <= 1'b0;
          div_go_q   <= 1'b0;
          stall_q    <= 1'b0;
        end
      endcase
    end
  end

  assign mult_go_o = mult_go_q;
  assign div_go_o  = div_go_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign stall_o   = stall_q;
  assign op_done_o = op_done_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl; expected HI/LO captures go through a scoreboard queue.
module tb_muldiv_hilo_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult, start_div, mthi, mtlo, mult_done, div_done;
  logic [31:0] divisor_in, wdata, mult_hi, mult_lo, div_hi, div_lo;
  logic        mult_go, div_go, stall, op_done, timeout, div_zero;
  logic [31:0] hi, lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_cyc;

  always #5 clk = ~clk;

  muldiv_hilo_ctrl #(.TIMEOUT_CYCLES(40)) dut (
    .clk(clk), .reset(reset),
    .start_mult_i(start_mult), .start_div_i(start_div), .divisor_in_i(divisor_in),
    .mthi_i(mthi), .mtlo_i(mtlo), .wdata_i(wdata),
    .mult_hi_i(mult_hi), .mult_lo_i(mult_lo), .div_hi_i(div_hi), .div_lo_i(div_lo),
    .mult_done_i(mult_done), .div_done_i(div_done),
    .mult_go_o(mult_go), .div_go_o(div_go), .hi_o(hi), .lo_o(lo),
    .stall_o(stall), .op_done_o(op_done), .timeout_o(timeout), .div_zero_o(div_zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected capture and compare it with HI/LO at an op_done pulse.
  task automatic check_capture(input string tag);
    exp_t e;
    chk({tag, "_op_done"}, {31'd0, op_done}, 32'd1);
    chk({tag, "_sb_nonempty"}, {31'd0, sb_q.size() > 0}, 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_hi"}, hi, e.hi);
      chk({tag, "_lo"}, lo, e.lo);
    end
  endtask

  initial begin
    reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; mthi = 1'b1; mtlo = 1'b1;
    mult_done = 1'b0; div_done = 1'b0; divisor_in = 32'd7; wdata = 32'hFFFF_FFFF;
    mult_hi = 32'd0; mult_lo = 32'd0; div_hi = 32'd0; div_lo = 32'd0;
    tick(); tick();
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_flags", {26'd0, mult_go, div_go, stall, op_done, timeout, div_zero}, 32'd0);
    reset = 1'b0; mthi = 1'b0; mtlo = 1'b0;

    // Multiply completing on the 5th wait cycle
    mult_hi = 32'h1; mult_lo = 32'h2; start_mult = 1'b1;
    tick(); start_mult = 1'b0;
    chk("mul_go", {30'd0, mult_go, div_go}, 32'd2);
    for (int i = 1; i <= 4; i++) begin
      chk("mul_stall", {31'd0, stall}, 32'd1);
      tick();
    end
    chk("mul_stall5", {31'd0, stall}, 32'd1);
    mult_done = 1'b1; sb_q.push_back('{hi: 32'h1, lo: 32'h2});
    tick(); mult_done = 1'b0;
    check_capture("mul");
    chk("mul_idle", {30'd0, stall, mult_go}, 32'd0);
    tick();
    chk("mul_op_done_once", {31'd0, op_done}, 32'd0);

    // Divide by 7, multiplier untouched
    div_hi = 32'd3; div_lo = 32'd5; divisor_in = 32'd7; start_div = 1'b1;
    tick(); start_div = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("div_go_held", {30'd0, div_go, mult_go}, 32'd2);
      tick();
    end
    div_done = 1'b1; sb_q.push_back('{hi: 32'd3, lo: 32'd5});
    tick(); div_done = 1'b0;
    check_capture("div");
    chk("div_go_off", {30'd0, div_go, mult_go}, 32'd0);

    // Simultaneous starts: divide wins, multiplier done ignored
    mult_hi = 32'hAAAA; mult_lo = 32'hBBBB; start_mult = 1'b1; start_div = 1'b1;
    tick(); start_mult = 1'b0; start_div = 1'b0;
    chk("both_go", {30'd0, div_go, mult_go}, 32'd2);
    mult_done = 1'b1;
    tick(); tick(); mult_done = 1'b0;
    chk("both_ignore_mdone", {30'd0, op_done, stall}, 32'd1);
    chk("both_hi_kept", hi, 32'd3);
    div_hi = 32'h11; div_lo = 32'h22; div_done = 1'b1; sb_q.push_back('{hi: 32'h11, lo: 32'h22});
    tick(); div_done = 1'b0;
    check_capture("both");

    // mthi in IDLE, mtlo and start_div ignored during MULT_WAIT
    mthi = 1'b1; wdata = 32'hDEAD;
    tick(); mthi = 1'b0;
    chk("mthi_idle", hi, 32'hDEAD);
    start_mult = 1'b1;
    tick(); start_mult = 1'b0;
    mtlo = 1'b1; wdata = 32'hBEEF; start_div = 1'b1;
    tick(); mtlo = 1'b0; start_div = 1'b0;
    chk("mtlo_busy", lo, 32'h22);
    chk("start_busy", {30'd0, div_go, mult_go}, 32'd1);
    mult_hi = 32'h5; mult_lo = 32'h6; mult_done = 1'b1; sb_q.push_back('{hi: 32'h5, lo: 32'h6});
    tick(); mult_done = 1'b0;
    check_capture("mul2");

    // Write plus start in one IDLE cycle, then divide timeout
    mtlo = 1'b1; wdata = 32'h1234; start_div = 1'b1; divisor_in = 32'd3;
    tick(); mtlo = 1'b0; start_div = 1'b0;
    chk("wr_start_lo", lo, 32'h1234);
    n_cyc = 0;
    while (stall && n_cyc < 100) begin
      n_cyc++;
      tick();
    end
    chk("to_cycles", n_cyc, 32'd40);
    chk("to_pulse", {29'd0, timeout, stall, op_done}, 32'd4);
    chk("to_hi", hi, 32'h5);
    chk("to_lo", lo, 32'h1234);
    tick();
    chk("to_once", {31'd0, timeout}, 32'd0);

    // Done coinciding with the timeout limit: capture wins
    start_mult = 1'b1;
    tick(); start_mult = 1'b0;
    for (int i = 0; i < 39; i++) tick();
    chk("edge_stall", {31'd0, stall}, 32'd1);
    mult_hi = 32'h77; mult_lo = 32'h88; mult_done = 1'b1; sb_q.push_back('{hi: 32'h77, lo: 32'h88});
    tick(); mult_done = 1'b0;
    chk("edge_no_timeout", {31'd0, timeout}, 32'd0);
    check_capture("edge");

    // Zero divisor, with a concurrent multiply request
    divisor_in = 32'd0; start_div = 1'b1; start_mult = 1'b1;
    tick(); start_div = 1'b0; start_mult = 1'b0;
`ifdef DIV_ZERO_EXC_EN
    chk("dz_pulse", {28'd0, div_zero, div_go, mult_go, stall}, 32'h8);
    tick();
    chk("dz_once", {31'd0, div_zero}, 32'd0);
    chk("dz_hi", hi, 32'h77);
`else
    chk("dz_launch", {28'd0, div_zero, div_go, mult_go, stall}, 32'h5);
    div_hi = 32'h99; div_lo = 32'h9A; div_done = 1'b1; sb_q.push_back('{hi: 32'h99, lo: 32'h9A});
    tick(); div_done = 1'b0;
    check_capture("dz");
`endif

    // Reset mid-DIV_WAIT
    tick();
    divisor_in = 32'd9; start_div = 1'b1;
    tick(); start_div = 1'b0;
    chk("rst_mid_go", {31'd0, div_go}, 32'd1);
    tick();
    reset = 1'b1;
    tick(); reset = 1'b0;
    chk("rst_mid_flags", {28'd0, div_go, mult_go, stall, op_done}, 32'd0);
    chk("rst_mid_hilo", hi | lo, 32'd0);
    tick();
    chk("rst_mid_after", {30'd0, div_go, stall}, 32'd0);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
